// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings, response constants and slave FSM states.
package ahb_pkg;
    typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
    typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD} hsize_t;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} slv_state_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_BYTE ? 4'b0001 << a :
               size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb_sram_bank.sv
// ahb_sram_bank: MEM_WORDS x 32 storage, byte-lane write enables, async read, async zero reset.
module ahb_sram_bank #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  we,
    input  logic [5:0]  idx,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] words [MEM_WORDS];
    logic [31:0] bm;
    assign bm = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    for (genvar w = 0; w < MEM_WORDS; w++) begin : g_w
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                words[w] <= '0;
            else if (idx == 6'(w) && |we)
                words[w] <= (words[w] & ~bm) | (wdata & bm);
    end
    assign rdata = words[idx];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR.
// Define AHB_SLV_PROT_EN to make user-mode writes to the upper half of memory an error.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [7:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    slv_state_t state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        dp_valid, dp_write;
    logic [5:0]  dp_idx;
    logic [3:0]  dp_mask;
    logic        accept, addr_err, done;
    logic [7:0]  widx;
    logic [31:0] rdata;
    logic        unused_ok;
    assign unused_ok = ^{HBURST, HPROT};
    assign widx   = {2'b0, HADDR[7:2]};
    assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && state == ST_IDLE;
    assign done   = state == ST_IDLE && dp_valid;
    always_comb begin
        addr_err = HSIZE > 3'd2 || (HSIZE == HSIZE_HALF && HADDR[0]) ||
                   (HSIZE == HSIZE_WORD && |HADDR[1:0]) || widx >= 8'(MEM_WORDS);
`ifdef AHB_SLV_PROT_EN
        addr_err = addr_err || (HWRITE && !HPROT[1] && widx >= 8'(MEM_WORDS / 2));
`endif
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE:
                if (accept && addr_err)
                    state_nx = ST_ERR1;
                else if (accept && WAIT_STATES > 0) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = 3'(WAIT_STATES - 1);
                end
            ST_WAIT: begin
                state_nx = cnt == 3'd0 ? ST_IDLE : ST_WAIT;
                cnt_nx   = cnt - 3'd1;
            end
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge HCLK or negedge HRESET)
        if (!HRESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_mask  <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            dp_valid <= accept ? !addr_err : dp_valid && !done;
            if (accept) begin
                dp_write <= HWRITE;
                dp_idx   <= HADDR[7:2];
                dp_mask  <= lane_mask(HSIZE, HADDR[1:0]);
            end
        end
    // Only OKAY transfers set dp_valid, so errored writes never reach the bank.
    ahb_sram_bank #(.MEM_WORDS(MEM_WORDS)) u_bank (
        .clk   (HCLK),
        .rst_n (HRESET),
        .we    (done && dp_write ? dp_mask : 4'b0000),
        .idx   (dp_idx),
        .wdata (HWDATA),
        .rdata (rdata)
    );
    assign HREADYOUT = state == ST_IDLE || state == ST_ERR2;
    assign HRESP     = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = done && !dp_write ? rdata : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench for a zero-wait and a three-wait ahb_sram_slave on one bus.
module tb_ahb_sram_slave;
    typedef struct { logic resp; logic [31:0] data; int waits; } exp_t;
    logic        HCLK = 1'b0, HRESET = 1'b0;
    logic        hsel = 1'b0, hwrite = 1'b0, dsel = 1'b0;
    logic [7:0]  haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0, hburst = '0;
    logic [3:0]  hprot = '0;
    logic [31:0] hwdata = '0;
    logic        ro0, ro1, rs0, rs1, hready, hresp;
    logic [31:0] rd0, rd1, hrdata;
    exp_t        sb[$];
    int          total = 0, passed = 0;

    always #5 HCLK = ~HCLK;
    assign hready = dsel ? ro1 : ro0;
    assign hresp  = dsel ? rs1 : rs0;
    assign hrdata = dsel ? rd1 : rd0;

    ahb_sram_slave #(.MEM_WORDS(64), .WAIT_STATES(0)) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && !dsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));
    ahb_sram_slave #(.MEM_WORDS(64), .WAIT_STATES(3)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && dsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge HCLK);
        while (!hready && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (!hready) begin
            total++;
            $display("FAIL %s: HREADYOUT stuck at 0, required 1", name);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [3:0] p, input logic push, input exp_t e);
        hsel = 1'b1; haddr = a; htrans = 2'd2; hwrite = w; hsize = sz; hprot = p;
        if (push) sb.push_back(e);
        wait_ready("accept_timeout");
        hwdata = wd; hsel = 1'b0; htrans = 2'd0;
    endtask

    task automatic idle();
        hsel = 1'b0; htrans = 2'd0;
        wait_ready("idle_timeout");
    endtask

    task automatic xfer(input logic [7:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [3:0] p, input logic [31:0] rexp, input logic er);
        exp_t e;
        e.resp = er; e.data = er ? 32'h0 : rexp; e.waits = er ? 1 : (dsel ? 3 : 0);
        issue(a, w, sz, wd, p, 1'b1, e);
        if (er) idle();
    endtask

    // Monitor: tracks each accepted data phase, counts low-ready cycles, compares on completion.
    initial begin
        logic in_dp = 1'b0, lowresp = 1'b0;
        int   waits = 0;
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (!HRESET) in_dp = 1'b0;
            else begin
                if (in_dp && hready) begin
                    in_dp = 1'b0;
                    if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
                    else begin
                        e = sb.pop_front();
                        chk("hresp", 32'(hresp), 32'(e.resp));
                        chk("hrdata", hrdata, e.data);
                        chk("wait_cycles", waits, e.waits);
                        if (e.waits > 0) chk("hresp_low_phase", 32'(lowresp), 32'(e.resp));
                    end
                end else if (in_dp) begin
                    waits++;
                    lowresp = lowresp | hresp;
                end
                if (hsel && hready && htrans[1]) begin
                    in_dp = 1'b1; waits = 0; lowresp = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t none;
        none.resp = 1'b0; none.data = '0; none.waits = 0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", 32'(ro0), 32'd1);
        chk("rst_hresp", 32'(rs0), 32'd0);
        chk("rst_hrdata", rd0, 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        xfer(8'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0);
        xfer(8'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        xfer(8'h21, 1'b1, 3'd0, 32'hAAAAAAAA, 4'h0, 32'h0, 1'b0);
        xfer(8'h20, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0000AA00, 1'b0);
        xfer(8'h03, 1'b1, 3'd1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b1);
        xfer(8'h00, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(8'h22, 1'b1, 3'd1, 32'h12345678, 4'h0, 32'h0, 1'b0);
        xfer(8'h20, 1'b0, 3'd2, 32'h0, 4'h0, 32'h1234AA00, 1'b0);
        xfer(8'h41, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(8'h00, 1'b0, 3'd3, 32'h0, 4'h0, 32'h0, 1'b1);
`ifdef AHB_SLV_PROT_EN
        xfer(8'h80, 1'b1, 3'd2, 32'h11111111, 4'h0, 32'h0, 1'b1);
        xfer(8'h80, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b0);
`else
        xfer(8'h80, 1'b1, 3'd2, 32'h11111111, 4'h0, 32'h0, 1'b0);
        xfer(8'h80, 1'b0, 3'd2, 32'h0, 4'h0, 32'h11111111, 1'b0);
`endif
        xfer(8'h80, 1'b1, 3'd2, 32'h22222222, 4'h2, 32'h0, 1'b0);
        xfer(8'h81, 1'b0, 3'd0, 32'h0, 4'h0, 32'h22222222, 1'b0);
        xfer(8'hFC, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b0);
        idle();
        dsel = 1'b1;
        xfer(8'h04, 1'b1, 3'd2, 32'hCAFEF00D, 4'h0, 32'h0, 1'b0);
        xfer(8'h04, 1'b0, 3'd2, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        xfer(8'h01, 1'b1, 3'd1, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(8'h04, 1'b0, 3'd2, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        issue(8'h08, 1'b1, 3'd2, 32'h12345678, 4'h0, 1'b0, none);
        @(posedge HCLK);
        #2;
        chk("pre_abort_hreadyout", 32'(ro1), 32'd0);
        HRESET = 1'b0;
        #1;
        chk("abort_hreadyout", 32'(ro1), 32'd1);
        chk("abort_hresp", 32'(rs1), 32'd0);
        chk("abort_hrdata", rd1, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        xfer(8'h08, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b0);
        idle();
        repeat (3) @(posedge HCLK);
        chk("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
